// File: rtl/dlsc_pcie_s6_outbound_pkg.sv
// Shared constants and types for the outbound read/write TLP scheduler.
package dlsc_pcie_s6_outbound_pkg;

  localparam int unsigned LEN_W   = 10;
  localparam int unsigned MAX_LEN = 1024;
  localparam int unsigned WCNT_W  = 4;
  localparam int unsigned BEAT_W  = LEN_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_HDR  = 2'd1,
    ST_WR_HDR  = 2'd2,
    ST_WR_DATA = 2'd3
  } state_t;

  // Payload beats for a header length field; an all-zero field means MAX_LEN.
  function automatic logic [BEAT_W-1:0] beats_of(input logic [LEN_W-1:0] len);
    return (len == '0) ? BEAT_W'(MAX_LEN) : {1'b0, len};
  endfunction

endpackage

// File: rtl/dlsc_pcie_s6_outbound_sched_if.sv
// Header/data handshake bundle between the read/write requesters, the
// scheduler (slave modport) and the outbound TLP formatter.
interface dlsc_pcie_s6_outbound_sched_if #(
  parameter int ADDR = 32,
  parameter int TAG  = 5
);
  import dlsc_pcie_s6_outbound_pkg::*;

  logic              rd_h_ready;
  logic              rd_h_valid;
  logic [ADDR-1:2]   rd_h_addr;
  logic [LEN_W-1:0]  rd_h_len;
  logic [TAG-1:0]    rd_h_tag;
  logic [3:0]        rd_h_be_first;
  logic [3:0]        rd_h_be_last;

  logic              wr_h_ready;
  logic              wr_h_valid;
  logic [ADDR-1:2]   wr_h_addr;
  logic [LEN_W-1:0]  wr_h_len;
  logic [3:0]        wr_h_be_first;
  logic [3:0]        wr_h_be_last;

  logic              wr_d_ready;
  logic              wr_d_valid;
  logic [31:0]       wr_d_data;
  logic              wr_d_last;

  logic              tlp_h_ready;
  logic              tlp_h_valid;
  logic              tlp_h_write;
  logic [ADDR-1:2]   tlp_h_addr;
  logic [LEN_W-1:0]  tlp_h_len;
  logic [TAG-1:0]    tlp_h_tag;
  logic [3:0]        tlp_h_be_first;
  logic [3:0]        tlp_h_be_last;

  logic              tlp_d_ready;
  logic              tlp_d_valid;
  logic [31:0]       tlp_d_data;
  logic              tlp_d_last;

  modport slave (
    input  rd_h_valid, rd_h_addr, rd_h_len, rd_h_tag, rd_h_be_first, rd_h_be_last,
    output rd_h_ready,
    input  wr_h_valid, wr_h_addr, wr_h_len, wr_h_be_first, wr_h_be_last,
    output wr_h_ready,
    input  wr_d_valid, wr_d_data, wr_d_last,
    output wr_d_ready,
    input  tlp_h_ready,
    output tlp_h_valid, tlp_h_write, tlp_h_addr, tlp_h_len, tlp_h_tag,
    output tlp_h_be_first, tlp_h_be_last,
    input  tlp_d_ready,
    output tlp_d_valid, tlp_d_data, tlp_d_last
  );

  modport master (
    output rd_h_valid, rd_h_addr, rd_h_len, rd_h_tag, rd_h_be_first, rd_h_be_last,
    input  rd_h_ready,
    output wr_h_valid, wr_h_addr, wr_h_len, wr_h_be_first, wr_h_be_last,
    input  wr_h_ready,
    output wr_d_valid, wr_d_data, wr_d_last,
    input  wr_d_ready,
    output tlp_h_ready,
    input  tlp_h_valid, tlp_h_write, tlp_h_addr, tlp_h_len, tlp_h_tag,
    input  tlp_h_be_first, tlp_h_be_last,
    output tlp_d_ready,
    input  tlp_d_valid, tlp_d_data, tlp_d_last
  );

endinterface

// File: rtl/dlsc_pcie_s6_outbound_sched_wrr.sv
// Two-request weighted round-robin picker. The pick is combinational from
// the registered last grant and run-length counter; both update on advance.
module dlsc_pcie_s6_outbound_sched_wrr
  import dlsc_pcie_s6_outbound_pkg::*;
#(
  parameter int unsigned RD_WEIGHT = 2,
  parameter int unsigned WR_WEIGHT = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_rd,
  input  logic req_wr,
  input  logic advance,
  output logic pick_wr
);

  logic              last_wr;
  logic [WCNT_W-1:0] wcnt;

  // Keep the previous winner while its run is below weight, else hand over.
  always_comb begin
    pick_wr = req_wr;
    if (req_rd && req_wr) begin
      if (last_wr) pick_wr = (wcnt < WCNT_W'(WR_WEIGHT));
      else         pick_wr = !(wcnt < WCNT_W'(RD_WEIGHT));
    end
  end

  // Record the grant and extend or restart the saturating run counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_wr <= 1'b1;
      wcnt    <= '0;
    end else if (advance) begin
      last_wr <= pick_wr;
      if (pick_wr != last_wr) wcnt <= WCNT_W'(1);
      else if (wcnt != '1)    wcnt <= wcnt + WCNT_W'(1);
    end
  end

endmodule

// File: rtl/dlsc_pcie_s6_outbound_sched.sv
// Outbound scheduler: arbitrates read headers against write header+data
// TLPs onto one formatter port, frames write payload from the header length
// and flags wr_d_last disagreements. Optional statistics counters are
// enabled with DLSC_PCIE_OUTBOUND_SCHED_STATS_EN.
module dlsc_pcie_s6_outbound_sched
  import dlsc_pcie_s6_outbound_pkg::*;
#(
  parameter int          ADDR      = 32,
  parameter int          TAG       = 5,
  parameter int unsigned RD_WEIGHT = 2,
  parameter int unsigned WR_WEIGHT = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic dma_en,
  input  logic err_clr,
  output logic busy,
  output logic err_len,
`ifdef DLSC_PCIE_OUTBOUND_SCHED_STATS_EN
  output logic [31:0] stat_rd_cnt,
  output logic [31:0] stat_wr_cnt,
  output logic [31:0] stat_stall_cnt,
`endif
  dlsc_pcie_s6_outbound_sched_if.slave bus
);

  state_t            state, state_nxt;
  logic [BEAT_W-1:0] beat_cnt;
  logic              advance, pick_wr, beat_load, beat_dec, err_set;
  logic [ADDR-1:2]   h_addr;
  logic [TAG-1:0]    h_tag;

  dlsc_pcie_s6_outbound_sched_wrr #(
    .RD_WEIGHT (RD_WEIGHT),
    .WR_WEIGHT (WR_WEIGHT)
  ) u_wrr (
    .clk     (clk),
    .rst_n   (rst_n),
    .req_rd  (bus.rd_h_valid),
    .req_wr  (bus.wr_h_valid),
    .advance (advance),
    .pick_wr (pick_wr)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next state and handshake muxing, decoded from the state register only.
  always_comb begin
    state_nxt       = state;
    advance         = 1'b0;
    beat_load       = 1'b0;
    beat_dec        = 1'b0;
    err_set         = 1'b0;
    bus.rd_h_ready  = 1'b0;
    bus.wr_h_ready  = 1'b0;
    bus.wr_d_ready  = 1'b0;
    bus.tlp_h_valid = 1'b0;
    bus.tlp_h_write = 1'b0;
    bus.tlp_d_valid = 1'b0;
    bus.tlp_d_last  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (dma_en && (bus.rd_h_valid || bus.wr_h_valid)) begin
          advance   = 1'b1;
          state_nxt = pick_wr ? ST_WR_HDR : ST_RD_HDR;
        end
      end
      ST_RD_HDR: begin
        bus.tlp_h_valid = bus.rd_h_valid;
        bus.rd_h_ready  = bus.tlp_h_ready;
        if (bus.rd_h_valid && bus.tlp_h_ready) state_nxt = ST_IDLE;
      end
      ST_WR_HDR: begin
        bus.tlp_h_valid = bus.wr_h_valid;
        bus.tlp_h_write = 1'b1;
        bus.wr_h_ready  = bus.tlp_h_ready;
        if (bus.wr_h_valid && bus.tlp_h_ready) begin
          beat_load = 1'b1;
          state_nxt = ST_WR_DATA;
        end
      end
      ST_WR_DATA: begin
        bus.tlp_d_valid = bus.wr_d_valid;
        bus.wr_d_ready  = bus.tlp_d_ready;
        bus.tlp_d_last  = (beat_cnt == BEAT_W'(1));
        if (bus.wr_d_valid && bus.tlp_d_ready) begin
          beat_dec = 1'b1;
          err_set  = (bus.wr_d_last != bus.tlp_d_last);
          if (beat_cnt == BEAT_W'(1)) state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Header field mux; tag is forced to zero for writes.
  always_comb begin
    h_addr             = bus.rd_h_addr;
    h_tag              = bus.rd_h_tag;
    bus.tlp_h_len      = bus.rd_h_len;
    bus.tlp_h_be_first = bus.rd_h_be_first;
    bus.tlp_h_be_last  = bus.rd_h_be_last;
    if (state == ST_WR_HDR) begin
      h_addr             = bus.wr_h_addr;
      h_tag              = '0;
      bus.tlp_h_len      = bus.wr_h_len;
      bus.tlp_h_be_first = bus.wr_h_be_first;
      bus.tlp_h_be_last  = bus.wr_h_be_last;
    end
  end

  assign bus.tlp_h_addr = h_addr;
  assign bus.tlp_h_tag  = h_tag;
  assign bus.tlp_d_data = bus.wr_d_data;
  assign busy           = (state != ST_IDLE);

  // Remaining payload beats of the current write TLP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         beat_cnt <= '0;
    else if (beat_load) beat_cnt <= beats_of(bus.wr_h_len);
    else if (beat_dec)  beat_cnt <= beat_cnt - BEAT_W'(1);
  end

  // Sticky length error; a new error takes priority over a clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       err_len <= 1'b0;
    else if (err_set) err_len <= 1'b1;
    else if (err_clr) err_len <= 1'b0;
  end

`ifdef DLSC_PCIE_OUTBOUND_SCHED_STATS_EN
  // Accepted header counts and formatter header stall cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_rd_cnt    <= '0;
      stat_wr_cnt    <= '0;
      stat_stall_cnt <= '0;
    end else begin
      if (bus.rd_h_valid && bus.rd_h_ready) stat_rd_cnt <= stat_rd_cnt + 32'd1;
      if (bus.wr_h_valid && bus.wr_h_ready) stat_wr_cnt <= stat_wr_cnt + 32'd1;
      if (bus.tlp_h_valid && !bus.tlp_h_ready) stat_stall_cnt <= stat_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dlsc_pcie_s6_outbound_sched.sv
// Self-checking bench for dlsc_pcie_s6_outbound_sched: vector table of
// read/write TLPs plus hand sequences, scored through expected-value queues.
module tb_dlsc_pcie_s6_outbound_sched;

  localparam int LIMIT = 5000;

  typedef struct packed {
    logic [29:0] addr;
    logic [9:0]  len;
    logic [4:0]  tag;
    logic [3:0]  bef;
    logic [3:0]  bel;
  } hdr_t;

  typedef struct {
    logic wr;
    hdr_t h;
    int   hmode;
    int   dmode;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n, dma_en, err_clr, busy, err_len;
  int   total = 0;
  int   bad   = 0;
  int   h_mode = 0;
  int   d_mode = 0;
  bit   in_wr = 0;

  hdr_t        exp_rd[$];
  hdr_t        exp_wr[$];
  logic [32:0] exp_d[$];
  bit          order[$];

  always #5 clk = ~clk;

  dlsc_pcie_s6_outbound_sched_if #(.ADDR(32), .TAG(5)) bus ();

`ifdef DLSC_PCIE_OUTBOUND_SCHED_STATS_EN
  logic [31:0] stat_rd_cnt, stat_wr_cnt, stat_stall_cnt;
`endif

  dlsc_pcie_s6_outbound_sched #(
    .ADDR(32), .TAG(5), .RD_WEIGHT(2), .WR_WEIGHT(1)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .dma_en  (dma_en),
    .err_clr (err_clr),
    .busy    (busy),
    .err_len (err_len),
`ifdef DLSC_PCIE_OUTBOUND_SCHED_STATS_EN
    .stat_rd_cnt    (stat_rd_cnt),
    .stat_wr_cnt    (stat_wr_cnt),
    .stat_stall_cnt (stat_stall_cnt),
`endif
    .bus     (bus.slave)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  // Formatter ready generator: 0 always, 1 toggle, 2 random, 3 held low.
  always @(posedge clk) begin
    #1;
    case (h_mode)
      0: bus.tlp_h_ready = 1'b1;
      1: bus.tlp_h_ready = ~bus.tlp_h_ready;
      2: bus.tlp_h_ready = 1'($urandom);
      default: bus.tlp_h_ready = 1'b0;
    endcase
    case (d_mode)
      0: bus.tlp_d_ready = 1'b1;
      1: bus.tlp_d_ready = ~bus.tlp_d_ready;
      2: bus.tlp_d_ready = 1'($urandom);
      default: bus.tlp_d_ready = 1'b0;
    endcase
  end

  // Output monitor: scores headers and beats, checks ready pass-through.
  always @(negedge clk) begin
    hdr_t        got, e;
    logic [32:0] ed;
    if (!rst_n) begin
      in_wr = 0;
    end else begin
      if (!busy)
        chk("idle_outputs", {59'd0, bus.rd_h_ready, bus.wr_h_ready, bus.wr_d_ready,
                             bus.tlp_h_valid, bus.tlp_d_valid}, 64'd0);
      if (bus.tlp_h_valid && !bus.tlp_h_write) chk("rd_ready_pass", bus.rd_h_ready, bus.tlp_h_ready);
      if (bus.tlp_h_valid && bus.tlp_h_write)  chk("wr_ready_pass", bus.wr_h_ready, bus.tlp_h_ready);
      if (bus.tlp_d_valid)                     chk("d_ready_pass", bus.wr_d_ready, bus.tlp_d_ready);
      if (bus.tlp_h_valid && bus.tlp_h_ready) begin
        got = {bus.tlp_h_addr, bus.tlp_h_len, bus.tlp_h_tag, bus.tlp_h_be_first, bus.tlp_h_be_last};
        order.push_back(bus.tlp_h_write);
        if (bus.tlp_h_write) begin
          if (exp_wr.size() == 0) chk("wr_hdr_unexpected", 1, 0);
          else begin e = exp_wr.pop_front(); chk("wr_hdr", got, e); end
          in_wr = 1;
        end else begin
          chk("rd_inside_write", in_wr, 0);
          if (exp_rd.size() == 0) chk("rd_hdr_unexpected", 1, 0);
          else begin e = exp_rd.pop_front(); chk("rd_hdr", got, e); end
        end
      end
      if (bus.tlp_d_valid && bus.tlp_d_ready) begin
        if (exp_d.size() == 0) chk("data_unexpected", 1, 0);
        else begin ed = exp_d.pop_front(); chk("data", {bus.tlp_d_last, bus.tlp_d_data}, ed); end
        if (bus.tlp_d_last) in_wr = 0;
      end
    end
  end

  // Called just after a rising edge; returns just after a rising edge.
  task automatic send_rd(input hdr_t h);
    int n = 0;
    exp_rd.push_back(h);
    bus.rd_h_valid = 1'b1;
    {bus.rd_h_addr, bus.rd_h_len, bus.rd_h_tag, bus.rd_h_be_first, bus.rd_h_be_last} = h;
    do begin @(negedge clk); n++; end
    while (!(bus.rd_h_valid && bus.rd_h_ready) && n < LIMIT);
    if (n >= LIMIT) chk("rd_hdr_timeout", 1, 0);
    @(posedge clk); #1;
    bus.rd_h_valid = 1'b0;
  endtask

  task automatic send_wr(input hdr_t h, input int last_at);
    hdr_t        e = h;
    int          nb = (h.len == 0) ? 1024 : int'(h.len);
    int          n = 0;
    logic [31:0] d;
    e.tag = '0;
    exp_wr.push_back(e);
    bus.wr_h_valid = 1'b1;
    {bus.wr_h_addr, bus.wr_h_len, bus.wr_h_be_first, bus.wr_h_be_last} = {h.addr, h.len, h.bef, h.bel};
    do begin @(negedge clk); n++; end
    while (!(bus.wr_h_valid && bus.wr_h_ready) && n < LIMIT);
    if (n >= LIMIT) chk("wr_hdr_timeout", 1, 0);
    @(posedge clk); #1;
    bus.wr_h_valid = 1'b0;
    for (int i = 0; i < nb; i++) begin
      d = $urandom;
      exp_d.push_back({(i == nb - 1), d});
      bus.wr_d_valid = 1'b1;
      bus.wr_d_data  = d;
      bus.wr_d_last  = (i == last_at);
      n = 0;
      do begin @(negedge clk); n++; end
      while (!(bus.wr_d_valid && bus.wr_d_ready) && n < LIMIT);
      if (n >= LIMIT) begin chk("wr_data_timeout", 1, 0); break; end
      @(posedge clk); #1;
    end
    bus.wr_d_valid = 1'b0;
    bus.wr_d_last  = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired t=%0t", $time);
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[7];
    hdr_t h;
    int   n;

    vecs[0] = '{1'b0, '{30'h1234567, 10'd1,   5'd0,  4'h1, 4'h0}, 0, 0};
    vecs[1] = '{1'b1, '{30'h80,      10'd3,   5'd0,  4'hF, 4'hF}, 0, 1};
    vecs[2] = '{1'b0, '{30'h3FFFFFFF,10'd0,   5'd31, 4'hF, 4'hC}, 2, 0};
    vecs[3] = '{1'b1, '{30'h11,      10'd1,   5'd0,  4'h3, 4'h0}, 2, 2};
    vecs[4] = '{1'b1, '{30'h2000,    10'd0,   5'd0,  4'hE, 4'h7}, 0, 0};
    vecs[5] = '{1'b0, '{30'h55,      10'h3FF, 5'd17, 4'h8, 4'h1}, 1, 1};
    vecs[6] = '{1'b1, '{30'h777,     10'd5,   5'd0,  4'hF, 4'h3}, 2, 2};

    rst_n = 1'b0; dma_en = 1'b1; err_clr = 1'b0;
    bus.rd_h_valid = 0; bus.rd_h_addr = '0; bus.rd_h_len = '0; bus.rd_h_tag = '0;
    bus.rd_h_be_first = '0; bus.rd_h_be_last = '0;
    bus.wr_h_valid = 0; bus.wr_h_addr = '0; bus.wr_h_len = '0;
    bus.wr_h_be_first = '0; bus.wr_h_be_last = '0;
    bus.wr_d_valid = 0; bus.wr_d_data = '0; bus.wr_d_last = 0;
    bus.tlp_h_ready = 0; bus.tlp_d_ready = 0;
    #2;
    chk("reset_outputs", {57'd0, busy, err_len, bus.rd_h_ready, bus.wr_h_ready,
                          bus.wr_d_ready, bus.tlp_h_valid, bus.tlp_d_valid}, 64'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // First read: one bubble, then header held until the formatter accepts.
    h_mode = 3;
    @(posedge clk); #1;
    h = '{30'h40, 10'd4, 5'd3, 4'hF, 4'hF};
    exp_rd.push_back(h);
    bus.rd_h_valid = 1'b1;
    {bus.rd_h_addr, bus.rd_h_len, bus.rd_h_tag, bus.rd_h_be_first, bus.rd_h_be_last} = h;
    @(negedge clk);
    chk("lat_bubble", bus.tlp_h_valid, 0);
    @(negedge clk);
    chk("lat_valid", {bus.tlp_h_valid, bus.tlp_h_write, bus.tlp_h_tag}, {1'b1, 1'b0, 5'd3});
    chk("lat_ready_low", bus.rd_h_ready, 0);
    h_mode = 0;
    @(negedge clk);
    chk("lat_ready_high", bus.rd_h_ready, 1);
    @(posedge clk); #1;
    bus.rd_h_valid = 1'b0;

    // Vector table.
    for (int i = 0; i < 7; i++) begin
      h_mode = vecs[i].hmode;
      d_mode = vecs[i].dmode;
      @(posedge clk); #1;
      if (vecs[i].wr) send_wr(vecs[i].h, (vecs[i].h.len == 0) ? 1023 : int'(vecs[i].h.len) - 1);
      else            send_rd(vecs[i].h);
    end
    h_mode = 0; d_mode = 0;
    @(negedge clk);
    chk("err_clean", err_len, 0);
    @(posedge clk); #1;

    // Weighted order with both requesters always valid.
    send_wr('{30'h9, 10'd1, 5'd0, 4'hF, 4'h0}, 0);
    order.delete();
    fork
      for (int i = 0; i < 4; i++) send_rd('{30'($urandom), 10'($urandom), 5'($urandom), 4'hF, 4'hF});
      for (int j = 0; j < 2; j++) send_wr('{30'(j + 100), 10'd2, 5'd0, 4'hF, 4'hF}, 1);
    join
    chk("wrr_count", order.size(), 6);
    if (order.size() == 6) begin
      chk("wrr_order", {order[0], order[1], order[2], order[3], order[4], order[5]}, 6'b001001);
    end

    // Early wr_d_last: flagged, but the counter still frames four beats.
    send_wr('{30'h300, 10'd4, 5'd0, 4'hF, 4'hF}, 1);
    @(negedge clk);
    chk("err_set", err_len, 1);
    @(posedge clk); #1 err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;
    @(negedge clk);
    chk("err_cleared", err_len, 0);
    @(posedge clk); #1;

    // dma_en dropped mid-payload: TLP completes, no new grant until re-enabled.
    d_mode = 1;
    fork
      send_wr('{30'h400, 10'd8, 5'd0, 4'hF, 4'hF}, 7);
      begin
        n = 0;
        do begin @(negedge clk); n++; end
        while (!(bus.tlp_h_valid && bus.tlp_h_ready && bus.tlp_h_write) && n < LIMIT);
        @(posedge clk); #1 dma_en = 1'b0;
      end
    join
    chk("dma_beats_done", exp_d.size(), 0);
    h = '{30'h500, 10'd2, 5'd9, 4'hF, 4'hF};
    exp_rd.push_back(h);
    bus.rd_h_valid = 1'b1;
    {bus.rd_h_addr, bus.rd_h_len, bus.rd_h_tag, bus.rd_h_be_first, bus.rd_h_be_last} = h;
    repeat (5) begin
      @(negedge clk);
      chk("dma_blocked", {busy, bus.tlp_h_valid}, 0);
    end
    @(posedge clk); #1 dma_en = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end
    while (!(bus.rd_h_valid && bus.rd_h_ready) && n < LIMIT);
    if (n >= LIMIT) chk("dma_resume_timeout", 1, 0);
    @(posedge clk); #1 bus.rd_h_valid = 1'b0;

    // Asynchronous reset in the middle of a write payload.
    d_mode = 0;
    @(posedge clk); #1;
    exp_wr.push_back('{30'h600, 10'd4, 5'd0, 4'hF, 4'hF});
    bus.wr_h_valid = 1'b1;
    {bus.wr_h_addr, bus.wr_h_len, bus.wr_h_be_first, bus.wr_h_be_last} = {30'h600, 10'd4, 4'hF, 4'hF};
    n = 0;
    do begin @(negedge clk); n++; end
    while (!(bus.wr_h_valid && bus.wr_h_ready) && n < LIMIT);
    @(posedge clk); #1 bus.wr_h_valid = 1'b0;
    @(negedge clk);
    chk("rst_pre_wrdata", {busy, bus.wr_d_ready}, 2'b11);
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    chk("rst_async", {58'd0, busy, bus.rd_h_ready, bus.wr_h_ready, bus.wr_d_ready,
                      bus.tlp_h_valid, bus.tlp_d_valid}, 64'd0);
    h = '{30'h700, 10'd1, 5'd21, 4'h1, 4'h0};
    exp_rd.push_back(h);
    bus.rd_h_valid = 1'b1;
    {bus.rd_h_addr, bus.rd_h_len, bus.rd_h_tag, bus.rd_h_be_first, bus.rd_h_be_last} = h;
    @(posedge clk); #1 rst_n = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end
    while (!(bus.tlp_h_valid && bus.tlp_h_ready) && n < LIMIT);
    chk("rst_first_grant_read", {n < LIMIT, bus.tlp_h_write}, 2'b10);
    @(posedge clk); #1 bus.rd_h_valid = 1'b0;

    repeat (3) @(posedge clk);
    chk("left_rd", exp_rd.size(), 0);
    chk("left_wr", exp_wr.size(), 0);
    chk("left_data", exp_d.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
